rf_writeback_unit: RTL and testbench
====================================

// Module: rf_writeback_unit
// PURPOSE
//  Sole writer of the RV32 register file. Merges ALU results and load returns onto the single write port (wa/wda/reg_wr).
//  ALU has priority. Load returns that lose arbitration queue in a small FIFO with kill-by-rd to keep program order.
//  Exports a pending-load scoreboard for decode stalls.
// PARAMETERS
//  DEPTH  4   load FIFO entries, power of two, >=2
//  XLEN   32  data width
//  RAW    5   register address width
// PORTS
//  clock       in   1         clock
//  reset       in   1         synchronous, active-low
//  alu_valid   in   1         ALU result valid this cycle (no backpressure)
//  alu_rd      in   RAW       ALU destination register
//  alu_data    in   XLEN      ALU result
//  ld_valid    in   1         load return valid
//  ld_ready    out  1         load return accepted when ld_valid&&ld_ready
//  ld_rd       in   RAW       load destination register
//  ld_data     in   XLEN      load data
//  wa          out  RAW       regfile write address (registered)
//  wda         out  XLEN      regfile write data (registered)
//  reg_wr      out  1         regfile write enable (registered)
//  pending     out  32        bit r set: live queued load targets xr; bit0 always 0
//  fifo_count  out  clog2(DEPTH+1)  queued entries, live+dead
// BEHAVIOUR
//  - Reset (reset==0 at posedge): wa=0, wda=0, reg_wr=0, fifo_count=0, pending=0, all entries invalid.
//    Mid-operation reset discards queued loads; no write issues on the following cycle.
//  - ld_ready = (fifo_count < DEPTH), computed from the registered count. No accept at full even if a pop occurs in the same cycle.
//  - Handshakes with rd==0 complete but are dropped. The same applies to ALU results with rd==0.
//  - Per-cycle source select (priority order). The result drives wa/wda/reg_wr at the next posedge, so latency is 1 cycle:
//    ALU:    alu_valid && alu_rd!=0 -> write ALU. Clear valid on every FIFO entry with rd==alu_rd.
//            A load accepted in the same cycle with ld_rd==alu_rd is enqueued dead (load is older).
//            Any other accepted load is enqueued live.
//    HEAD:   FIFO non-empty -> pop head. Live head: write it. Dead head: reg_wr<=0.
//            An accepted load is enqueued in the same cycle.
//    DIRECT: FIFO empty && load accepted && ld_rd!=0 -> write load directly without enqueuing.
//    IDLE:   reg_wr<=0. wa/wda hold their previous values.
//  - Loads drain in acceptance order. Dead entries occupy slots until popped.
//  - pending is a combinational OR-decode over live entries. It updates the cycle after a push or kill.
//  - The FIFO uses circular pointers that wrap at DEPTH. Push and pop in the same cycle leave fifo_count unchanged.
// CONFIGURATION
//  WB_BYPASS_EN defined: adds fwd_ra (in, RAW), fwd_hit (out, 1) and fwd_data (out, XLEN), all combinational.
//    fwd_hit = reg_wr && wa==fwd_ra && fwd_ra!=0. fwd_data = wda when hit, else 0.
//    This covers the write-then-read-same-cycle gap of the registered regfile.
//  WB_BYPASS_EN undefined: the three ports are absent. No other behavioural change.
// STRUCTURE
//  Shared package rv32_pkg: XLEN, REG_AW, typedef wb_entry_t {logic valid; logic [REG_AW-1:0] rd; logic [XLEN-1:0] data}.
//  Sub-module wb_load_fifo provides:
//    - DEPTH-entry ring of wb_entry_t
//    - push/pop interface with count output
//    - kill_en/kill_rd ports that clear matching valids
//    - per-entry valid/rd outputs for the pending decode
//  Top level: source-select logic, output registers, pending decode, optional bypass.
// TESTING
//  1. Reset low 2 cycles with all inputs active -> reg_wr=0, wa=0, wda=0, pending=0, ld_ready=1 after release.
//  2. ALU x5=0x11 alone -> next cycle wa=5, wda=0x11, reg_wr=1. Then idle -> reg_wr=0.
//  3. ALU x3=0xA and load x7=0xB in the same cycle -> cycle+1 writes x3=0xA, cycle+2 writes x7=0xB.
//     pending[7]=1 for exactly 1 cycle.
//  4. ALU writes x1..x6 each cycle while loads x10..x15 return -> ld_ready=0 after 4 accepts.
//     Loads then drain x10..x13 in order after the ALU stops.
//  5. Load x9=0x1 queued, then ALU x9=0x2 -> x9=0x2 written. Dead pop produces a reg_wr=0 cycle.
//     x9 is never written with 0x1. pending[9] clears the cycle after the kill.
//  6. ALU and load to x0 -> no write. With WB_BYPASS_EN: after ALU x4=0x55, fwd_ra=4 in the write cycle gives fwd_hit=1, fwd_data=0x55.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: register file geometry, queued-load entry and source-select encoding.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_HEAD = 2'd2,
    SRC_LOAD = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Ring of queued load returns with kill-by-rd; valid bit marks a live entry.
// Latency: push visible at head next cycle. Backpressure: caller must not push when full or pop when empty.
module wb_load_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic [CW-1:0]                 count,
  input  logic                          kill_en,
  input  logic [REG_AW-1:0]             kill_rd,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign head = mem[rd_ptr];

  always_comb begin
    ent_valid = '0;
    ent_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem[i].valid;
      ent_rd[i]    = mem[i].rd;
    end
  end

  // Popped slots drop their valid so ent_valid only ever reflects live queued loads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].rd == kill_rd) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= PW'(rd_ptr + 1'b1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= PW'(wr_ptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Sole RV32 regfile writer: ALU beats queued loads beats direct load; optional bypass under WB_BYPASS_EN.
// Latency: 1 cycle to wa/wda/reg_wr. Backpressure: ALU never stalls; ld_ready drops while the load queue is full.
module rf_writeback_unit
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rv32_pkg::XLEN,
  parameter int RAW   = rv32_pkg::REG_AW
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [RAW-1:0]              alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [RAW-1:0]              ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  output logic [RAW-1:0]              wa,
  output logic [XLEN-1:0]             wda,
  output logic                        reg_wr,
  output logic [31:0]                 pending,
`ifdef WB_BYPASS_EN
  input  logic [RAW-1:0]              fwd_ra,
  output logic                        fwd_hit,
  output logic [XLEN-1:0]             fwd_data,
`endif
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t                    head;
  wb_entry_t                    push_entry;
  logic                         push;
  logic                         pop;
  logic                         kill_en;
  logic [REG_AW-1:0]            kill_rd;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic [CW-1:0]                count;
  logic                         accept;
  logic                         alu_sel;
  logic                         ld_live_rd;
  logic                         fifo_empty;
  wb_src_e                      src;

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign ld_ready   = (count < DEPTH_C);
  assign fifo_count = count;
  assign accept     = ld_valid && ld_ready;
  assign alu_sel    = alu_valid && (alu_rd != '0);
  assign ld_live_rd = (ld_rd != '0);
  assign fifo_empty = (count == '0);

  always_comb begin
    src              = SRC_IDLE;
    push             = 1'b0;
    pop              = 1'b0;
    kill_en          = alu_sel;
    kill_rd          = alu_rd;
    push_entry.valid = 1'b1;
    push_entry.rd    = ld_rd;
    push_entry.data  = ld_data;
    if (alu_sel) begin
      src              = SRC_ALU;
      push             = accept && ld_live_rd;
      // The load is older than this ALU result, so it must never land.
      push_entry.valid = (ld_rd != alu_rd);
    end else if (!fifo_empty) begin
      src  = SRC_HEAD;
      pop  = 1'b1;
      push = accept && ld_live_rd;
    end else if (accept && ld_live_rd) begin
      src = SRC_LOAD;
    end
  end

  wb_load_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_load_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .kill_en    (kill_en),
    .kill_rd    (kill_rd),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      wa     <= '0;
      wda    <= '0;
      reg_wr <= 1'b0;
    end else begin
      case (src)
        SRC_ALU: begin
          wa     <= alu_rd;
          wda    <= alu_data;
          reg_wr <= 1'b1;
        end
        SRC_HEAD: begin
          reg_wr <= head.valid;
          if (head.valid) begin
            wa  <= head.rd;
            wda <= head.data;
          end
        end
        SRC_LOAD: begin
          wa     <= ld_rd;
          wda    <= ld_data;
          reg_wr <= 1'b1;
        end
        default: reg_wr <= 1'b0;
      endcase
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        pending[ent_rd[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit  = reg_wr && (wa == fwd_ra) && (fwd_ra != '0);
  assign fwd_data = fwd_hit ? wda : '0;
`endif

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Bench for rf_writeback_unit: directed scenarios then random traffic against a queue-based reference model.
module tb_rf_writeback_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  wa;
  logic [31:0] wda;
  logic        reg_wr;
  logic [31:0] pending;
  logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  fwd_ra = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  rf_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .wa         (wa),
    .wda        (wda),
    .reg_wr     (reg_wr),
    .pending    (pending),
`ifdef WB_BYPASS_EN
    .fwd_ra     (fwd_ra),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int rd;
    int data;
    bit live;
  } ld_t;

  ld_t q[$];
  int  m_wa, m_wda;
  bit  m_wr;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (q[i]) if (q[i].live && q[i].rd != 0) p[q[i].rd] = 1'b1;
    return p;
  endfunction

  // Applies one clock edge of the writeback rules to the model, using the stimulus currently driven.
  task automatic model_step();
    bit acc;
    int ard, lrd;
    ard = int'(alu_rd);
    lrd = int'(ld_rd);
    if (!reset) begin
      q.delete();
      m_wa = 0; m_wda = 0; m_wr = 0;
      return;
    end
    acc = ld_valid && (q.size() < DEPTH);
    if (alu_valid && ard != 0) begin
      foreach (q[i]) if (q[i].rd == ard) q[i].live = 0;
      m_wr = 1; m_wa = ard; m_wda = int'(alu_data);
      if (acc && lrd != 0) q.push_back('{lrd, int'(ld_data), lrd != ard});
    end else if (q.size() > 0) begin
      ld_t e = q.pop_front();
      m_wr = e.live;
      if (e.live) begin m_wa = e.rd; m_wda = e.data; end
      if (acc && lrd != 0) q.push_back('{lrd, int'(ld_data), 1'b1});
    end else if (acc && lrd != 0) begin
      m_wr = 1; m_wa = lrd; m_wda = int'(ld_data);
    end else begin
      m_wr = 0;
    end
  endtask

  task automatic compare_all();
    chk("reg_wr", 32'(reg_wr), 32'(m_wr));
    chk("wa", 32'(wa), 32'(m_wa));
    chk("wda", wda, 32'(m_wda));
    chk("pending", pending, model_pending());
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("ld_ready", 32'(ld_ready), 32'(q.size() < DEPTH));
`ifdef WB_BYPASS_EN
    fwd_ra = 5'($urandom_range(0, 7));
    #1;
    chk("fwd_hit", 32'(fwd_hit), 32'(m_wr && m_wa == int'(fwd_ra) && fwd_ra != 0));
    chk("fwd_data", fwd_data, (m_wr && m_wa == int'(fwd_ra) && fwd_ra != 0) ? 32'(m_wda) : 32'd0);
`endif
  endtask

  // Called just after a negedge: check state, drive the next stimulus, advance one cycle.
  task automatic cycle(input bit av, input int ard, input int adat,
                       input bit lv, input int lrd, input int ldat);
    compare_all();
    alu_valid = av; alu_rd = 5'(ard); alu_data = 32'(adat);
    ld_valid  = lv; ld_rd  = 5'(lrd); ld_data  = 32'(ldat);
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held two cycles with both sources active.
    alu_valid = 1; alu_rd = 5; alu_data = 32'h77;
    ld_valid  = 1; ld_rd  = 6; ld_data  = 32'h66;
    for (int i = 0; i < 2; i++) begin
      model_step();
      @(posedge clock);
      @(negedge clock);
    end
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wda", wda, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    reset = 1;
    idle(1);

    cycle(1, 5, 32'h11, 0, 0, 0);
    chk("alu5_wa", 32'(wa), 32'd5);
    chk("alu5_wda", wda, 32'h11);
    chk("alu5_wr", 32'(reg_wr), 32'd1);
    idle(1);
    chk("alu5_idle_wr", 32'(reg_wr), 32'd0);

    cycle(1, 3, 32'hA, 1, 7, 32'hB);
    chk("mix_wa3", 32'(wa), 32'd3);
    chk("mix_pend7_set", 32'(pending[7]), 32'd1);
    idle(1);
    chk("mix_wa7", 32'(wa), 32'd7);
    chk("mix_wda7", wda, 32'hB);
    chk("mix_pend7_clr", 32'(pending[7]), 32'd0);
    idle(1);

    for (int k = 0; k < 6; k++) begin
      if (k == 4) chk("full_ld_ready", 32'(ld_ready), 32'd0);
      cycle(1, 1 + k, 32'h100 + k, 1, 10 + k, 32'h200 + k);
    end
    for (int j = 0; j < 4; j++) begin
      idle(1);
      chk("drain_wa", 32'(wa), 32'(10 + j));
      chk("drain_wda", wda, 32'(32'h200 + j));
    end
    idle(1);

    cycle(1, 2, 32'h22, 1, 9, 32'h1);
    chk("kill_pend9_set", 32'(pending[9]), 32'd1);
    cycle(1, 9, 32'h2, 0, 0, 0);
    chk("kill_wda", wda, 32'h2);
    chk("kill_pend9_clr", 32'(pending[9]), 32'd0);
    idle(1);
    chk("kill_dead_pop", 32'(reg_wr), 32'd0);
    idle(1);

    cycle(1, 0, 32'h33, 1, 0, 32'h44);
    chk("x0_reg_wr", 32'(reg_wr), 32'd0);
    chk("x0_count", 32'(fifo_count), 32'd0);
`ifdef WB_BYPASS_EN
    cycle(1, 4, 32'h55, 0, 0, 0);
    fwd_ra = 4;
    #1;
    chk("byp_hit", 32'(fwd_hit), 32'd1);
    chk("byp_data", fwd_data, 32'h55);
`endif
    idle(1);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      cycle($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom);
    end
    reset = 1;
    idle(8);
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
